// File: rtl/cube_cmd_pkg.sv
// Shared constants, decode table and FSM encoding
// for the Bluetooth cube command decoder.
package cube_cmd_pkg;

    typedef logic [3:0] cmd_t;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_D = 3'd1;
    localparam logic [2:0] FACE_L = 3'd2;
    localparam logic [2:0] FACE_R = 3'd3;
    localparam logic [2:0] FACE_F = 3'd4;
    localparam logic [2:0] FACE_B = 3'd5;

    localparam cmd_t CMD_RESET = 4'b0111;

    localparam logic [7:0] ASC_U  = 8'h55;
    localparam logic [7:0] ASC_D  = 8'h44;
    localparam logic [7:0] ASC_L  = 8'h4C;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_F  = 8'h46;
    localparam logic [7:0] ASC_B  = 8'h42;
    localparam logic [7:0] ASC_X  = 8'h58;
    localparam logic [7:0] ASC_2  = 8'h32;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_LC = 8'h20;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_PUSH   = 2'd3;

    typedef enum logic [2:0] {
        DK_MOVE,
        DK_RESET,
        DK_SKIP,
        DK_HALF,
        DK_BAD
    } dec_kind_e;

    typedef struct packed {
        dec_kind_e kind;
        cmd_t      cmd;
    } dec_t;

    function automatic dec_t decode_byte(input logic [7:0] b);
        dec_t       d;
        logic       ccw;
        logic [7:0] up;
        ccw    = (b >= 8'h61) && (b <= 8'h7A);
        up     = ccw ? b - ASC_LC : b;
        d.kind = DK_BAD;
        d.cmd  = '0;
        case (up)
            ASC_U:  d = '{DK_MOVE, {ccw, FACE_U}};
            ASC_D:  d = '{DK_MOVE, {ccw, FACE_D}};
            ASC_L:  d = '{DK_MOVE, {ccw, FACE_L}};
            ASC_R:  d = '{DK_MOVE, {ccw, FACE_R}};
            ASC_F:  d = '{DK_MOVE, {ccw, FACE_F}};
            ASC_B:  d = '{DK_MOVE, {ccw, FACE_B}};
            ASC_X:  d = '{DK_RESET, CMD_RESET};
            ASC_2:  d.kind = DK_HALF;
            ASC_CR,
            ASC_LF,
            ASC_SP: d.kind = DK_SKIP;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cube_cmd_decoder_if.sv
// Command handshake from the decoder FIFO
// to the cube state engine.
interface cube_cmd_decoder_if;
    import cube_cmd_pkg::*;

    cmd_t cmd;
    logic cmd_valid;
    logic cmd_ready;

    modport master (
        output cmd,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        output cmd_ready
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop
// frees a slot for a push in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        dout    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cube_cmd_decoder.sv
// UART byte capture, ASCII move decode and command FIFO.
// Define DOUBLE_MOVE_EN to make '2' repeat the last move.
module cube_cmd_decoder
    import cube_cmd_pkg::*;
#(
    parameter int CAPTURE_DLY = 6000,
    parameter int FIFO_DEPTH  = 8,
    parameter int DLY_W       = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_byte,
    input  logic               rx_strobe,
    cube_cmd_decoder_if.master cmd_if,
    output logic               overflow,
    output logic               bad_byte
);

    localparam logic [DLY_W-1:0] CNT_LAST = DLY_W'(CAPTURE_DLY - 1);

    logic [2:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    cmd_t             cmd_q, cmd_d;
    logic             ovf_q, ovf_d;
`ifdef DOUBLE_MOVE_EN
    cmd_t             last_q, last_d;
    logic             last_vld_q, last_vld_d;
`endif

    logic fall;
    logic push;
    logic pop;
    logic bad;
    logic full;
    logic empty;
    cmd_t head;
    dec_t dec;

    assign pop = cmd_if.cmd_valid && cmd_if.cmd_ready;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (cmd_q),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        sync_d  = {sync_q[1:0], rx_strobe};
        fall    = sync_q[2] && !sync_q[1];
        dec     = decode_byte(byte_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        cmd_d   = cmd_q;
        push    = 1'b0;
        bad     = 1'b0;
`ifdef DOUBLE_MOVE_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + DLY_W'(1);
                if (cnt_q == CNT_LAST) begin
                    byte_d  = rx_byte;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                unique case (1'b1)
                    dec.kind == DK_MOVE,
                    dec.kind == DK_RESET: begin
                        cmd_d   = dec.cmd;
                        state_d = ST_PUSH;
                    end
`ifdef DOUBLE_MOVE_EN
                    dec.kind == DK_HALF && last_vld_q: begin
                        cmd_d   = last_q;
                        state_d = ST_PUSH;
                    end
`endif
                    dec.kind == DK_SKIP: ;
                    default: bad = 1'b1;
                endcase
            end
            default: begin
                push    = 1'b1;
                state_d = ST_IDLE;
`ifdef DOUBLE_MOVE_EN
                // a dropped push still defines what '2' repeats
                if (cmd_q == CMD_RESET) begin
                    last_vld_d = 1'b0;
                end else begin
                    last_d     = cmd_q;
                    last_vld_d = 1'b1;
                end
`endif
            end
        endcase
        ovf_d = ovf_q || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            cmd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef DOUBLE_MOVE_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            cmd_q   <= cmd_d;
            ovf_q   <= ovf_d;
`ifdef DOUBLE_MOVE_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
`endif
        end
    end

    assign cmd_if.cmd       = empty ? '0 : head;
    assign cmd_if.cmd_valid = !empty;
    assign overflow         = ovf_q;
    assign bad_byte         = bad;

endmodule

// File: tb/tb_cube_cmd_decoder.sv
// Randomised scoreboard bench for cube_cmd_decoder
// (short capture delay to keep runs brief).
module tb_cube_cmd_decoder;

    localparam int DLY = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       overflow;
    logic       bad_byte;

    cube_cmd_decoder_if cif ();

    cube_cmd_decoder #(
        .CAPTURE_DLY (DLY),
        .FIFO_DEPTH  (8),
        .DLY_W       (13)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .cmd_if    (cif),
        .overflow  (overflow),
        .bad_byte  (bad_byte)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int bad_seen = 0;
    int bad_exp = 0;
    logic ovf_exp = 1'b0;
    logic bad_prev = 1'b0;
    logic rnd_en = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] last_mv = 4'h0;
    logic last_vld = 1'b0;
    string faces = "UDLRFB";

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // 0 move, 1 reset, 2 ignored, 3 unrecognised, 4 repeat
    function automatic int classify(input logic [7:0] b,
                                    output logic [3:0] c);
        c = 4'h0;
        for (int i = 0; i < 6; i++) begin
            if (b == 8'(faces[i])) begin
                c = {1'b0, 3'(i)};
                return 0;
            end
            if (b == 8'(faces[i] + 8'd32)) begin
                c = {1'b1, 3'(i)};
                return 0;
            end
        end
        if (b == "X" || b == "x") return 1;
        if (b == 8'h0D || b == 8'h0A || b == 8'h20) return 2;
        if (b == "2") return 4;
        return 3;
    endfunction

    task automatic try_push(input logic [3:0] c);
        if (exp_q.size() < 8) exp_q.push_back(c);
        else ovf_exp = 1'b1;
    endtask

    task automatic model_apply(input logic [7:0] b);
        logic [3:0] c;
        int k;
        k = classify(b, c);
        case (k)
            0: begin
                try_push(c);
                last_mv = c;
                last_vld = 1'b1;
            end
            1: begin
                try_push(4'b0111);
                last_vld = 1'b0;
            end
            2: ;
            4: begin
`ifdef DOUBLE_MOVE_EN
                if (last_vld) try_push(last_mv);
                else bad_exp++;
`else
                bad_exp++;
`endif
            end
            default: bad_exp++;
        endcase
    endtask

    // model update lands 1 time unit after the FIFO write edge
    task automatic send(input logic [7:0] b, input int co_n,
                        output int lat);
        lat = -1;
        @(posedge clk);
        #1;
        rx_byte = b;
        rx_strobe = 1'b1;
        repeat (10) @(posedge clk);
        #1 rx_strobe = 1'b0;
        for (int n = 1; n <= DLY + 8; n++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && cif.cmd_valid) lat = n;
            if (co_n > 0 && n == co_n - 1) cif.cmd_ready = 1'b1;
            if (co_n > 0 && n == co_n) cif.cmd_ready = 1'b0;
            if (n == DLY + 5) model_apply(b);
        end
    endtask

    task automatic drain(input string nm, input int n_exp);
        int p0;
        int t;
        p0 = pops;
        t = 0;
        @(posedge clk);
        #1 cif.cmd_ready = 1'b1;
        while (cif.cmd_valid && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        cif.cmd_ready = 1'b0;
        chk({nm, "_pops"}, pops - p0, n_exp);
        chk({nm, "_valid"}, cif.cmd_valid, 1'b0);
        chk({nm, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst && cif.cmd_valid && cif.cmd_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected none",
                             cif.cmd);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_cmd", cif.cmd, e);
                end
            end
            if (bad_byte) begin
                bad_seen++;
                chk("bad_pulse_len", bad_prev, 1'b0);
            end
            bad_prev = bad_byte;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) cif.cmd_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] pool [12];
        logic [7:0] b;
        pool = '{"U", "d", "L", "r", "F", "b", "X", "x",
                 8'h0D, 8'h20, "2", "Q"};
        cif.cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", cif.cmd, 4'h0);
        chk("rst_valid", cif.cmd_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_bad", bad_byte, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        cif.cmd_ready = 1'b1;
        send("R", 0, lat);
        chk("r_latency", lat, DLY + 5);
        chk("r_valid_drop", cif.cmd_valid, 1'b0);
        cif.cmd_ready = 1'b0;

        send("u", 0, lat);
        send("X", 0, lat);
        send(8'h0A, 0, lat);
        chk("lf_silent", bad_seen, 0);
        send("Q", 0, lat);
        chk("q_bad", bad_seen, 1);
        chk("mix_valid", cif.cmd_valid, 1'b1);
        drain("mix", 2);

        send("2", 0, lat);
        send("L", 0, lat);
        send("2", 0, lat);
        send("X", 0, lat);
        send("2", 0, lat);
        chk("two_bad", bad_seen, bad_exp);
        drain("two", exp_q.size());

        for (int i = 0; i < 9; i++) begin
            send("F", 0, lat);
            if (i == 7) chk("ovf_at8", overflow, 1'b0);
        end
        chk("ovf_at9", overflow, 1'b1);
        chk("full_valid", cif.cmd_valid, 1'b1);

        @(posedge clk);
        #1;
        rx_byte = "B";
        rx_strobe = 1'b1;
        repeat (10) @(posedge clk);
        #1 rx_strobe = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", cif.cmd_valid, 1'b0);
        chk("arst_cmd", cif.cmd, 4'h0);
        chk("arst_ovf", overflow, 1'b0);
        chk("arst_bad", bad_byte, 1'b0);
        exp_q.delete();
        ovf_exp = 1'b0;
        last_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (DLY + 20) @(posedge clk);
        #1;
        chk("arst_no_cmd", cif.cmd_valid, 1'b0);

        for (int i = 0; i < 8; i++) send("F", 0, lat);
        chk("fill_ovf", overflow, 1'b0);
        send("F", DLY + 5, lat);
        chk("coinc_ovf", overflow, 1'b0);
        drain("coinc", 8);

        rnd_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 11)];
            send(b, 0, lat);
        end
        rnd_en = 1'b0;
        drain("rnd", exp_q.size());
        chk("rnd_ovf", overflow, ovf_exp);
        chk("rnd_bad", bad_seen, bad_exp);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cube_cmd_decoder.md
Name: cube_cmd_decoder

Overview:
- Sits directly downstream of the 9600-baud Bluetooth UART receiver and consumes its received byte and strobe.
- Captures each received byte once and decodes ASCII move characters into 4-bit cube move commands.
- Buffers the commands in an 8-entry FIFO that feeds the cube state engine over a valid/ready handshake.

Parameters:
- CAPTURE_DLY, 6000, cycles after the strobe falling edge before the byte is latched. It must exceed half a bit period (5209 at 100 MHz) so that bit 7 is already sampled.
- FIFO_DEPTH, 8, number of command FIFO entries (power of two).
- DLY_W, 13, width of the capture delay counter.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- rx_byte  in  8  byte from the receiver; bit 7 becomes valid only late in the frame
- rx_strobe  in  1  receiver strobe, a level held for about one bit period per frame
- cmd  out  4  head-of-FIFO command: {ccw, face[2:0]}
- cmd_valid  out  1  FIFO not empty
- cmd_ready  in  1  consumer accepts cmd when cmd_valid and cmd_ready are both high
- overflow  out  1  sticky; set when a command is dropped because the FIFO is full
- bad_byte  out  1  one-cycle pulse when a captured byte is not a recognised character

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: cmd=0, cmd_valid=0, overflow=0, bad_byte=0, FIFO empty, FSM in IDLE, delay counter 0.
- rx_strobe is synchronised through a 2-flop chain. A falling edge on the synchronised signal starts a capture.
- FSM IDLE: on the strobe falling edge, load the delay counter with 0 and go to WAIT.
- FSM WAIT: increment the counter. When it reaches CAPTURE_DLY-1, latch rx_byte and go to DECODE.
- FSM WAIT: any new falling edge during WAIT is ignored; the line cannot legally produce one.
- FSM DECODE (1 cycle): map the latched byte to a command, then go to PUSH, or to IDLE if there is nothing to push.
- FSM PUSH (1 cycle): write the command to the FIFO, then go to IDLE.
- Decode table, face codes: 'U'=0, 'D'=1, 'L'=2, 'R'=3, 'F'=4, 'B'=5.
- Decode table, direction: uppercase letters give ccw=0; the same letters in lowercase give ccw=1.
- Decode table, reset: 'X' or 'x' maps to the reset-cube command 4'b0111.
- Ignored bytes: CR (0x0D), LF (0x0A) and space (0x20) produce nothing and no bad_byte.
- Unrecognised bytes: any other byte pulses bad_byte in DECODE and pushes nothing.
- Face code 6 is never generated.
- Latency: cmd_valid rises CAPTURE_DLY+3 cycles after the synchronised falling edge when the FIFO was empty.
- FIFO: pointers one bit wider than log2(FIFO_DEPTH) and wrap naturally. Full means the pointers differ only in the MSB; empty means they are equal.
- cmd is driven combinationally from the head entry.
- Pop occurs on cmd_valid && cmd_ready.
- Simultaneous push and pop while full: the pop frees a slot, so the push succeeds and overflow is not set.
- Push while full with no pop: the command is discarded and overflow is set. overflow clears only on reset.
- Pop while empty: no effect.
- Reset mid-capture aborts the capture. The FIFO contents are lost.

Optional Feature:
- Macro: DOUBLE_MOVE_EN.
- Defined: a register holds the last pushed move command (reset command excluded) and a valid bit.
- Defined: the byte '2' pushes that command again, as a half turn. With no prior move, '2' is a bad byte.
- Defined: the reset command clears the valid bit; unrecognised bytes and overflow drops do not.
- Not defined: '2' is treated as an unrecognised byte.

Decomposition:
- Package cube_cmd_pkg holds:
  - face code localparams FACE_U through FACE_B;
  - CMD_RESET = 4'b0111;
  - ASCII constants for the recognised characters;
  - the FSM state encoding IDLE/WAIT/DECODE/PUSH as 2 bits.
- One sub-module, cmd_fifo: synchronous FIFO, parameterised by depth and width, with push/pop/full/empty outputs. The decoder FSM stays in the top.

Test Plan:
- Send 'R' (0x52) by toggling rx_strobe 1→0 → exactly CAPTURE_DLY+3 cycles after the synchronised edge, cmd_valid=1 and cmd=4'b0011; with cmd_ready=1 cmd_valid drops the next cycle.
- Send 'u', 'X', 0x0A, 'Q' with cmd_ready=0:
  - FIFO holds 4'b1000 then 4'b0111;
  - 0x0A is silently ignored;
  - 'Q' pulses bad_byte for one cycle;
  - cmd_valid stays high.
- Send 9 moves 'F' with cmd_ready=0 → 8 entries of 4'b0100, overflow=1 after the 9th; then drain with cmd_ready=1 → exactly 8 pops and cmd_valid=0.
- With the FIFO full, hold cmd_ready=1 and time a push to coincide with a pop → overflow stays 0 and the occupancy stays 8.
- Drop rst low during WAIT → all outputs go to 0 asynchronously and no command is produced after release.
- With DOUBLE_MOVE_EN defined:
  - 'L','2' → two entries of 4'b0010;
  - 'X','2' → 4'b0111 plus a bad_byte pulse;
  - with the macro undefined, '2' always pulses bad_byte.
